// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: warm-reset handshake plus the staged reset,
// status and lock-loss outputs of the reset sequencer.
interface reset_sequencer_if #(
   parameter int NUM_DOMAINS = 3
);
   logic                   soft_rst_req;
   logic                   soft_rst_ack;
   logic [NUM_DOMAINS-1:0] domain_rst_n;
   logic                   ready;
   logic [2:0]             state;
   logic [7:0]             lock_loss_ctr;

   modport master (
      input  soft_rst_req,
      output soft_rst_ack,
      output domain_rst_n,
      output ready,
      output state,
      output lock_loss_ctr
   );

   modport slave (
      output soft_rst_req,
      input  soft_rst_ack,
      input  domain_rst_n,
      input  ready,
      input  state,
      input  lock_loss_ctr
   );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: PLL-lock qualified, staged domain reset release.
// Optional lock-loss counter: RESET_SEQUENCER_LOCK_LOSS_CTR_EN.
module reset_sequencer #(
   parameter int NUM_DOMAINS  = 3,
   parameter int HOLD_CYCLES  = 100,
   parameter int STAGE_CYCLES = 16,
   parameter int SOFT_CYCLES  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pll_locked,
   reset_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      HOLD      = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      SOFT_RST  = 3'd4
   } state_t;

   typedef logic [NUM_DOMAINS-1:0] dom_t;

   localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] STAGE_LAST = 16'(STAGE_CYCLES - 1);
   localparam logic [15:0] SOFT_LAST  = 16'(SOFT_CYCLES - 1);

   logic [1:0]  sync_q;
   logic        locked_s;
   state_t      state_q;
   state_t      state_d;
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   dom_t        dom_q;
   dom_t        dom_d;
   dom_t        dom_next;
   logic        ready_q;
   logic        ready_d;
   logic        ack_q;
   logic        ack_d;
   logic        advance;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[0], pll_locked};
   end

   assign locked_s = sync_q[1];

   // Releasing one more domain is a shift-in of a 1 from the bottom.
   assign dom_next = (dom_q << 1) | dom_t'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      dom_d   = dom_q;
      ready_d = ready_q;
      ack_d   = 1'b0;
      advance = 1'b0;
      unique case (state_q)
         WAIT_LOCK: begin
            cnt_d   = '0;
            dom_d   = '0;
            ready_d = 1'b0;
            if (locked_s) state_d = HOLD;
         end
         HOLD:     advance = (cnt_q == HOLD_LAST);
         RELEASE:  advance = (cnt_q == STAGE_LAST);
         SOFT_RST: advance = (cnt_q == SOFT_LAST);
         RUN: begin
            cnt_d = '0;
            if (bus.soft_rst_req) begin
               state_d = SOFT_RST;
               dom_d   = '0;
               ready_d = 1'b0;
               ack_d   = 1'b1;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            dom_d   = '0;
            ready_d = 1'b0;
         end
      endcase

      if (advance) begin
         dom_d = dom_next;
         cnt_d = '0;
         if (&dom_next) begin
            state_d = RUN;
            ready_d = 1'b1;
         end else begin
            state_d = RELEASE;
         end
      end

      // Lock loss overrides any expiry or warm-reset request this cycle.
      if (!locked_s && state_q != WAIT_LOCK) begin
         state_d = WAIT_LOCK;
         cnt_d   = '0;
         dom_d   = '0;
         ready_d = 1'b0;
         ack_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         dom_q   <= '0;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dom_q   <= dom_d;
         ready_q <= ready_d;
         ack_q   <= ack_d;
      end
   end

`ifdef RESET_SEQUENCER_LOCK_LOSS_CTR_EN
   logic       lost;
   logic [7:0] llc_q;

   assign lost = !locked_s &&
                 (state_q inside {HOLD, RELEASE, RUN, SOFT_RST});

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          llc_q <= '0;
      else if (lost && llc_q != 8'hFF)  llc_q <= llc_q + 8'd1;
   end

   assign bus.lock_loss_ctr = llc_q;
`else
   assign bus.lock_loss_ctr = 8'd0;
`endif

   assign bus.soft_rst_ack = ack_q;
   assign bus.domain_rst_n = dom_q;
   assign bus.ready        = ready_q;
   assign bus.state        = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: vector table plus randomized run against an
// event-time reference model of the reset sequencer.
module tb_reset_sequencer;
   localparam int N     = 3;
   localparam int HOLD  = 100;
   localparam int STAGE = 16;
   localparam int SOFT  = 32;
`ifdef RESET_SEQUENCER_LOCK_LOSS_CTR_EN
   localparam bit CTR_EN = 1'b1;
`else
   localparam bit CTR_EN = 1'b0;
`endif

   logic clk;
   logic rst;
   logic pll;
   logic req;

   reset_sequencer_if #(.NUM_DOMAINS(N)) bus ();
   assign bus.soft_rst_req = req;

   reset_sequencer #(
      .NUM_DOMAINS (N),
      .HOLD_CYCLES (HOLD),
      .STAGE_CYCLES(STAGE),
      .SOFT_CYCLES (SOFT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pll_locked(pll),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: sequence described by the edge at which bit 0
   // is released; later bits follow arithmetically.
   bit m_p1, m_p2;
   bit m_up, m_soft, m_ack;
   int m_rel;
   int m_llc;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_p1 = 0; m_p2 = 0; m_up = 0; m_soft = 0;
      m_ack = 0; m_rel = 0; m_llc = 0;
   endtask

   task automatic model_edge(bit p, bit r);
      bit lk;
      lk = m_p2;
      m_p2 = m_p1;
      m_p1 = p;
      m_ack = 0;
      if (!m_up) begin
         if (lk) begin
            m_up = 1; m_soft = 0; m_rel = cyc + HOLD;
         end
      end else if (!lk) begin
         m_up = 0;
         if (m_llc < 255) m_llc++;
      end else if (r && (cyc - 1 >= m_rel + (N - 1) * STAGE)) begin
         m_ack = 1; m_soft = 1; m_rel = cyc + SOFT;
      end
   endtask

   task automatic model_check();
      int cnt;
      int st;
      cnt = 0;
      if (m_up && cyc >= m_rel) begin
         cnt = 1 + (cyc - m_rel) / STAGE;
         if (cnt > N) cnt = N;
      end
      if (!m_up)           st = 0;
      else if (cyc < m_rel) st = m_soft ? 4 : 1;
      else if (cnt < N)    st = 2;
      else                 st = 3;
      chk("m_dom", 32'(bus.domain_rst_n), 32'((1 << cnt) - 1));
      chk("m_ready", 32'(bus.ready), 32'(cnt == N));
      chk("m_state", 32'(bus.state), 32'(st));
      chk("m_ack", 32'(bus.soft_rst_ack), 32'(m_ack));
      chk("m_llc", 32'(bus.lock_loss_ctr), CTR_EN ? 32'(m_llc) : 32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge(pll, req);
      #1;
      model_check();
   endtask

   typedef struct {
      bit       pll;
      bit       req;
      int       n;
      bit [2:0] dom;
      bit       rdy;
      bit [2:0] st;
      bit       ack;
      int       llc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit p, bit r, int n, bit [2:0] d,
                               bit rd, bit [2:0] s, bit a, int l);
      vec_t v;
      v.pll = p; v.req = r; v.n = n; v.dom = d;
      v.rdy = rd; v.st = s; v.ack = a; v.llc = l;
      return v;
   endfunction

   initial begin
      rst = 1'b1; pll = 1'b1; req = 1'b0;
      model_reset();

      tbl.push_back(mk(1, 0, 102, 3'b000, 0, 1, 0, 0));
      tbl.push_back(mk(1, 0,   1, 3'b001, 0, 2, 0, 0));
      tbl.push_back(mk(1, 0,  15, 3'b001, 0, 2, 0, 0));
      tbl.push_back(mk(1, 0,   1, 3'b011, 0, 2, 0, 0));
      tbl.push_back(mk(1, 0,  15, 3'b011, 0, 2, 0, 0));
      tbl.push_back(mk(1, 0,   1, 3'b111, 1, 3, 0, 0));
      tbl.push_back(mk(1, 0,   5, 3'b111, 1, 3, 0, 0));
      tbl.push_back(mk(0, 0,   2, 3'b111, 1, 3, 0, 0));
      tbl.push_back(mk(0, 0,   1, 3'b000, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 102, 3'b000, 0, 1, 0, 1));
      tbl.push_back(mk(1, 0,   1, 3'b001, 0, 2, 0, 1));
      tbl.push_back(mk(1, 0,  32, 3'b111, 1, 3, 0, 1));
      tbl.push_back(mk(1, 1,   1, 3'b000, 0, 4, 1, 1));
      tbl.push_back(mk(1, 0,   1, 3'b000, 0, 4, 0, 1));
      tbl.push_back(mk(1, 0,  30, 3'b000, 0, 4, 0, 1));
      tbl.push_back(mk(1, 0,   1, 3'b001, 0, 2, 0, 1));
      tbl.push_back(mk(1, 0,  32, 3'b111, 1, 3, 0, 1));
      tbl.push_back(mk(0, 0,   3, 3'b000, 0, 0, 0, 2));
      tbl.push_back(mk(1, 1, 103, 3'b001, 0, 2, 0, 2));
      tbl.push_back(mk(1, 1,  31, 3'b011, 0, 2, 0, 2));
      tbl.push_back(mk(1, 1,   1, 3'b111, 1, 3, 0, 2));
      tbl.push_back(mk(1, 1,   1, 3'b000, 0, 4, 1, 2));
      tbl.push_back(mk(1, 0,   1, 3'b000, 0, 4, 0, 2));
      tbl.push_back(mk(1, 0,  63, 3'b111, 1, 3, 0, 2));
      tbl.push_back(mk(0, 0,   2, 3'b111, 1, 3, 0, 2));
      tbl.push_back(mk(0, 1,   1, 3'b000, 0, 0, 0, 3));
      tbl.push_back(mk(0, 0,   2, 3'b000, 0, 0, 0, 3));

      repeat (3) @(posedge clk);
      #1;
      chk("rst_dom", 32'(bus.domain_rst_n), 32'd0);
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_ack", 32'(bus.soft_rst_ack), 32'd0);
      chk("rst_llc", 32'(bus.lock_loss_ctr), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         pll = tbl[i].pll;
         req = tbl[i].req;
         repeat (tbl[i].n) step();
         chk($sformatf("v%0d_dom", i), 32'(bus.domain_rst_n), 32'(tbl[i].dom));
         chk($sformatf("v%0d_rdy", i), 32'(bus.ready), 32'(tbl[i].rdy));
         chk($sformatf("v%0d_st", i), 32'(bus.state), 32'(tbl[i].st));
         chk($sformatf("v%0d_ack", i), 32'(bus.soft_rst_ack), 32'(tbl[i].ack));
         chk($sformatf("v%0d_llc", i), 32'(bus.lock_loss_ctr),
             CTR_EN ? 32'(tbl[i].llc) : 32'd0);
      end

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) pll = ~pll;
         if ($urandom_range(0, 29) == 0)  req = ~req;
         step();
      end

      req = 1'b0;
      for (int i = 0; i < 300; i++) begin
         pll = 1'b1;
         repeat (4) step();
         pll = 1'b0;
         repeat (4) step();
      end
      chk("sat_llc", 32'(bus.lock_loss_ctr), CTR_EN ? 32'd255 : 32'd0);

      pll = 1'b1;
      repeat (108) step();
      chk("mid_state", 32'(bus.state), 32'd2);
      chk("mid_dom", 32'(bus.domain_rst_n), 32'b001);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_dom", 32'(bus.domain_rst_n), 32'd0);
      chk("arst_ready", 32'(bus.ready), 32'd0);
      chk("arst_state", 32'(bus.state), 32'd0);
      chk("arst_ack", 32'(bus.soft_rst_ack), 32'd0);
      chk("arst_llc", 32'(bus.lock_loss_ctr), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (110) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
